// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcode encodings, the
// opcode legality check and the arbiter FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_EQ  = 4'b1000;

    // Callers zero-extend their opcode, so any set upper bit reads as illegal.
    localparam int unsigned OP_CHECK_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

    function automatic logic alu_op_legal(input logic [OP_CHECK_WIDTH-1:0] op);
        logic legal;
        legal = 1'b0;
        if (op == OP_CHECK_WIDTH'(ALU_AND) || op == OP_CHECK_WIDTH'(ALU_OR)  ||
            op == OP_CHECK_WIDTH'(ALU_ADD) || op == OP_CHECK_WIDTH'(ALU_XOR) ||
            op == OP_CHECK_WIDTH'(ALU_SUB) || op == OP_CHECK_WIDTH'(ALU_EQ)) begin
            legal = 1'b1;
        end
        return legal;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and rr_ptr only
// breaks ties when both requesters are valid.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        grant_valid = valid0 | valid1;
        grant       = 1'b0;
        unique case ({valid1, valid0})
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = rr_ptr;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters: accept one op,
// drive the ALU from registers for a cycle, then hold the result until consumed.
module alu_share_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_src_a,
    input  logic [DATA_WIDTH-1:0]    req0_src_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_src_a,
    input  logic [DATA_WIDTH-1:0]    req1_src_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,

    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp_result,
    output logic                     rsp_illegal,

    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    import alu_pkg::*;

    alu_arb_state_t           state_q, state_d;
    logic                     rr_ptr_q, rr_ptr_d;
    logic                     gnt_id_q, gnt_id_d;
    logic [DATA_WIDTH-1:0]    src_a_q, src_a_d;
    logic [DATA_WIDTH-1:0]    src_b_q, src_b_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic                     illegal_q, illegal_d;

    logic grant_valid;
    logic grant;
    logic rsp_handshake;

    rr_arb2 u_rr_arb2 (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign rsp_handshake = (gnt_id_q == 1'b0) ? rsp0_ready : rsp1_ready;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        op_d       = op_q;
        result_d   = result_q;
        illegal_d  = illegal_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    gnt_id_d   = grant;
                    src_a_d    = grant ? req1_src_a : req0_src_a;
                    src_b_d    = grant ? req1_src_b : req0_src_b;
                    op_d       = grant ? req1_op : req0_op;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // The ALU is fed from op_q/src_*_q, so its output is valid here.
                result_d  = alu_result;
                illegal_d = ~alu_op_legal(OP_CHECK_WIDTH'(op_q));
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_handshake) begin
                    rr_ptr_d = ~gnt_id_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            gnt_id_q  <= 1'b0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            op_q      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_id_q  <= gnt_id_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign rsp0_valid  = (state_q == RESP) && (gnt_id_q == 1'b0);
    assign rsp1_valid  = (state_q == RESP) && (gnt_id_q == 1'b1);
    assign rsp_result  = result_q;
    assign rsp_illegal = illegal_q;
    assign alu_src_a   = src_a_q;
    assign alu_src_b   = src_b_q;
    assign alu_op      = op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [3:0]  req_op [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_illegal;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    int checks;
    int errors;
    int prio;

    logic [3:0] op_tab [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h8, 4'hF, 4'h5};

    alu_share_arbiter #(
        .DATA_WIDTH    (32),
        .OPCODE_LENGTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req_valid[0]),
        .req0_ready  (req_ready[0]),
        .req0_src_a  (req_a[0]),
        .req0_src_b  (req_b[0]),
        .req0_op     (req_op[0]),
        .req1_valid  (req_valid[1]),
        .req1_ready  (req_ready[1]),
        .req1_src_a  (req_a[1]),
        .req1_src_b  (req_b[1]),
        .req1_op     (req_op[1]),
        .rsp0_valid  (rsp_valid[0]),
        .rsp0_ready  (rsp_ready[0]),
        .rsp1_valid  (rsp_valid[1]),
        .rsp1_ready  (rsp_ready[1]),
        .rsp_result  (rsp_result),
        .rsp_illegal (rsp_illegal),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: defined opcodes per the datapath, anything else yields 0.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0110: return a - b;
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [3:0] op);
        return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b1000});
    endfunction

    always_comb alu_result = alu_model(alu_op, alu_src_a, alu_src_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_illegal"}, 32'(rsp_illegal), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_result"}, rsp_result, 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_a[i]  = '0;
            req_b[i]  = '0;
            req_op[i] = '0;
        end
        @(negedge clk);
        chk_idle_outputs("reset");
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_reset");
        next_cycle();
        prio = 0;
    endtask

    // One accept/execute/respond transaction for requester w, starting and ending
    // just after a rising edge. raise_other asserts the other requester mid-flight.
    task automatic run_txn(input int w, input logic raise_other, input int hold,
                           input string tag);
        logic [31:0] ea, eb, eres;
        logic [3:0]  eop;
        logic        eill;
        ea   = req_a[w];
        eb   = req_b[w];
        eop  = req_op[w];
        eres = alu_model(eop, ea, eb);
        eill = ref_illegal(eop);

        @(negedge clk);
        chk({tag, "_ready_win"}, 32'(req_ready[w]), 32'd1);
        chk({tag, "_ready_lose"}, 32'(req_ready[1-w]), 32'd0);
        next_cycle();
        req_valid[w] = 1'b0;
        if (raise_other) req_valid[1-w] = 1'b1;

        @(negedge clk);
        chk({tag, "_exec_rsp"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_exec_op"}, 32'(alu_op), 32'(eop));
        chk({tag, "_exec_a"}, alu_src_a, ea);
        chk({tag, "_exec_b"}, alu_src_b, eb);
        next_cycle();

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'(2'b01 << w));
            chk({tag, "_hold_result"}, rsp_result, eres);
            chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
            next_cycle();
        end

        rsp_ready[w] = 1'b1;
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(2'b01 << w));
        chk({tag, "_rsp_result"}, rsp_result, eres);
        chk({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'(eill));
        chk({tag, "_rsp_ready"}, 32'(req_ready), 32'd0);
        next_cycle();
        rsp_ready[w] = 1'b0;
        prio = 1 - w;
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[r] = op;
        req_a[r]  = a;
        req_b[r]  = b;
    endtask

    initial begin
        int w;
        checks = 0;
        errors = 0;
        prio   = 0;

        do_reset();
        repeat (2) begin
            @(negedge clk);
            chk_idle_outputs("idle_stays");
            next_cycle();
        end

        // Single op
        set_req(0, 4'b0010, 32'd5, 32'd7);
        req_valid[0] = 1'b1;
        run_txn(0, 1'b0, 0, "add");

        // Both valid straight after reset: req0 first, then the re-request loses
        do_reset();
        set_req(0, 4'b0110, 32'd10, 32'd3);
        set_req(1, 4'b0011, 32'hF0, 32'hFF);
        req_valid = 2'b11;
        run_txn(0, 1'b0, 0, "both_r0");
        set_req(0, 4'b0010, 32'd1, 32'd2);
        req_valid[0] = 1'b1;
        run_txn(1, 1'b0, 0, "conflict_r1");
        run_txn(0, 1'b0, 0, "conflict_r0");

        // Backpressure on req1 while req0 waits
        set_req(1, 4'b1000, 32'd9, 32'd9);
        set_req(0, 4'b0001, 32'h1200, 32'h0034);
        req_valid[1] = 1'b1;
        run_txn(1, 1'b1, 5, "bp_eq");
        run_txn(0, 1'b0, 0, "bp_after");

        // Illegal opcode
        set_req(0, 4'b1111, 32'd3, 32'd4);
        req_valid[0] = 1'b1;
        run_txn(0, 1'b0, 1, "illegal");

        // Reset during EXEC drops the op
        set_req(0, 4'b0010, 32'd100, 32'd200);
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready[0]), 32'd1);
        next_cycle();
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst_in");
        next_cycle();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            next_cycle();
        end
        set_req(0, 4'b0000, 32'hFF00, 32'h0FF0);
        set_req(1, 4'b0001, 32'h00A0, 32'h000B);
        req_valid = 2'b11;
        run_txn(0, 1'b0, 0, "midrst_and");
        run_txn(1, 1'b0, 0, "midrst_r1");

        // Randomized traffic against the round-robin model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && $urandom_range(1, 0) == 1) begin
                    set_req(r, op_tab[$urandom_range(7, 0)], $urandom(), $urandom());
                    if ($urandom_range(3, 0) == 0) req_b[r] = req_a[r];
                    req_valid[r] = 1'b1;
                end
            end
            if (req_valid == 2'b00) begin
                w = int'($urandom_range(1, 0));
                set_req(w, op_tab[$urandom_range(7, 0)], $urandom(), $urandom());
                req_valid[w] = 1'b1;
            end
            if (req_valid == 2'b11) w = prio;
            else w = req_valid[1] ? 1 : 0;
            run_txn(w, 1'b0, int'($urandom_range(3, 0)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
